// File: rtl/uart_tx_sched_pkg.sv
// Shared types and constants for the uart_tx_scheduler slice.
package uart_tx_sched_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    FRAME  = 2'd2
  } state_e;

  localparam int BYTE_W  = 8;
  localparam int MAX_REQ = 8;
endpackage

// File: rtl/tx_rr_arbiter.sv
// Combinational round-robin pick: searches upward from ptr+1 with wrap-around.
import uart_tx_sched_pkg::*;

module tx_rr_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         grant_oh,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx
);
  localparam int IDX_W = $clog2(NUM_REQ);

  always_comb begin
    int   idx;
    logic found;
    grant_oh  = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int k = 1; k <= MAX_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!found && (k <= NUM_REQ) && req_valid[idx]) begin
        found         = 1'b1;
        grant_oh[idx] = 1'b1;
        grant_idx     = IDX_W'(idx);
      end
    end
  end
endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one uart_tx between NUM_REQ byte producers (round-robin, registered outputs).
// Optional launch watchdog enabled by defining UART_TX_SCHED_TIMEOUT_EN.
import uart_tx_sched_pkg::*;

module uart_tx_scheduler #(
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [BYTE_W*NUM_REQ-1:0]   req_byte,
  output logic [NUM_REQ-1:0]          req_ack,
  input  logic                        transmit_ready,
  output logic                        tx_ctrl,
  output logic [BYTE_W-1:0]           tx_byte,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id,
  output logic                        busy,
  output logic                        timeout_err
);
  localparam int IDX_W = $clog2(NUM_REQ);
  localparam logic [IDX_W-1:0] PTR_RST = IDX_W'(NUM_REQ - 1);

  state_e             state_q, state_d;
  logic               tx_ctrl_q, tx_ctrl_d;
  logic [BYTE_W-1:0]  tx_byte_q, tx_byte_d;
  logic [NUM_REQ-1:0] req_ack_q, req_ack_d;
  logic [IDX_W-1:0]   grant_id_q, grant_id_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic               busy_q, busy_d;
  logic [NUM_REQ-1:0] arb_oh;
  logic [IDX_W-1:0]   arb_idx;
  logic               grant_fire;
  logic               timeout_hit;

  tx_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req_valid (req_valid),
    .ptr       (ptr_q),
    .grant_oh  (arb_oh),
    .grant_idx (arb_idx)
  );

  // A grant is only made while the transmitter reports idle.
  assign grant_fire = (state_q == IDLE) && (|req_valid) && transmit_ready;

`ifdef UART_TX_SCHED_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_err_q, timeout_err_d;

  assign timeout_hit = (state_q == LAUNCH) && transmit_ready &&
                       (cnt_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    cnt_d         = (state_q == LAUNCH) ? cnt_q + CNT_W'(1) : '0;
    timeout_err_d = timeout_err_q | timeout_hit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q         <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign timeout_err = timeout_err_q;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT > 0);
  assign timeout_hit    = 1'b0;
  assign timeout_err    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      tx_ctrl_q  <= 1'b0;
      tx_byte_q  <= '0;
      req_ack_q  <= '0;
      grant_id_q <= '0;
      ptr_q      <= PTR_RST;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_ctrl_q  <= tx_ctrl_d;
      tx_byte_q  <= tx_byte_d;
      req_ack_q  <= req_ack_d;
      grant_id_q <= grant_id_d;
      ptr_q      <= ptr_d;
      busy_q     <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (grant_fire) state_d = LAUNCH;
      LAUNCH: begin
        if (!transmit_ready)  state_d = FRAME;
        else if (timeout_hit) state_d = IDLE;
      end
      FRAME:   if (transmit_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tx_ctrl_d  = (state_d == LAUNCH);
    busy_d     = (state_d != IDLE);
    req_ack_d  = '0;
    tx_byte_d  = tx_byte_q;
    grant_id_d = grant_id_q;
    ptr_d      = ptr_q;
    if (grant_fire) begin
      req_ack_d  = arb_oh;
      tx_byte_d  = req_byte[int'(arb_idx)*BYTE_W +: BYTE_W];
      grant_id_d = arb_idx;
      ptr_d      = arb_idx;
    end
  end

  assign tx_ctrl  = tx_ctrl_q;
  assign tx_byte  = tx_byte_q;
  assign req_ack  = req_ack_q;
  assign grant_id = grant_id_q;
  assign busy     = busy_q;
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: directed scenarios plus randomized traffic against a
// uart_tx model; expectations follow UART_TX_SCHED_TIMEOUT_EN when it is defined.
module tb_uart_tx_scheduler;
  localparam int NREQ = 3;
  localparam int GW   = $clog2(NREQ);
  localparam int CPB  = 4;

  typedef struct packed {
    logic [1:0] idx;
    logic [7:0] b;
  } req_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NREQ-1:0] req_valid;
  logic [8*NREQ-1:0] req_byte;
  logic [NREQ-1:0] req_ack;
  logic            transmit_ready;
  logic            tx_ctrl;
  logic [7:0]      tx_byte;
  logic [GW-1:0]   grant_id;
  logic            busy;
  logic            timeout_err;

  uart_tx_scheduler #(.NUM_REQ(NREQ), .TIMEOUT(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_byte       (req_byte),
    .req_ack        (req_ack),
    .transmit_ready (transmit_ready),
    .tx_ctrl        (tx_ctrl),
    .tx_byte        (tx_byte),
    .grant_id       (grant_id),
    .busy           (busy),
    .timeout_err    (timeout_err)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int n_acks   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  // producers: each holds one byte pending until acked
  logic [NREQ-1:0] pend = '0;
  logic [7:0]      pbyte [NREQ] = '{default: 8'h00};
  req_t            src_q[$];

  assign req_valid = pend;
  always_comb begin
    for (int i = 0; i < NREQ; i++) req_byte[8*i +: 8] = pbyte[i];
  end

  task automatic post(input int i, input logic [7:0] b);
    req_t r;
    r.idx = 2'(i);
    r.b   = b;
    src_q.push_back(r);
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < NREQ; i++) begin
      logic got;
      got = 1'b0;
      if (req_ack[i]) pend[i] = 1'b0;
      if (!pend[i]) begin
        for (int k = 0; k < src_q.size(); k++) begin
          if (!got && int'(src_q[k].idx) == i) begin
            pbyte[i] = src_q[k].b;
            pend[i]  = 1'b1;
            src_q.delete(k);
            got = 1'b1;
          end
        end
      end
    end
  end

  // uart_tx model: ready drops one cycle after tx_ctrl is seen, 10 bits of CPB cycles
  logic       model_en    = 1'b1;
  logic       force_ready = 1'b1;
  logic       m_busy      = 1'b0;
  logic       m_done      = 1'b0;
  logic [7:0] m_rx        = 8'h00;
  int         m_cnt       = 0;

  assign transmit_ready = model_en ? !m_busy : force_ready;

  always @(posedge clk) begin
    m_done <= 1'b0;
    if (!m_busy) begin
      if (model_en && tx_ctrl) begin
        m_busy <= 1'b1;
        m_cnt  <= 0;
      end
    end else begin
      if ((m_cnt % CPB) == 0 && m_cnt >= CPB && m_cnt < 9*CPB)
        m_rx[m_cnt/CPB - 1] <= tx_byte[m_cnt/CPB - 1];
      if (m_cnt == 10*CPB - 1) begin
        m_busy <= 1'b0;
        m_done <= 1'b1;
      end
      m_cnt <= m_cnt + 1;
    end
  end

  // reference arbitration: first pending requester after the last winner, wrapping
  function automatic int ref_winner(input logic [NREQ-1:0] v, input int p);
    for (int k = 1; k <= NREQ; k++) begin
      if (v[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  // scoreboard monitor
  logic [7:0] exp_q[$];
  int         ref_ptr = NREQ - 1;

  always @(posedge clk) begin
    int w;
    #1;
    if (rst) begin
      ref_ptr = NREQ - 1;
    end else if (req_ack != '0) begin
      w = ref_winner(pend, ref_ptr);
      if (w < 0) begin
        check("spurious_ack", 32'(req_ack), 32'd0);
      end else begin
        check("ack_onehot", 32'(req_ack), 32'(1) << w);
        check("ack_grant_id", 32'(grant_id), 32'(w));
        check("ack_tx_byte", 32'(tx_byte), 32'(pbyte[w]));
        ref_ptr = w;
        n_acks++;
        if (model_en) exp_q.push_back(pbyte[w]);
      end
    end
    if (m_done) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL serial_unexpected: got 0x%0h, expected no frame", m_rx);
      end else begin
        check("serial_byte", 32'(m_rx), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    int hi, bad, cyc, viol, ng, nr, acks0;
    logic prev_tx, prev_busy;
    logic [GW-1:0] gids [4];
    logic [7:0]    rxs  [4];

    // reset values
    reset_dut();
    check("rst_tx_ctrl", 32'(tx_ctrl), 32'd0);
    check("rst_tx_byte", 32'(tx_byte), 32'd0);
    check("rst_req_ack", 32'(req_ack), 32'd0);
    check("rst_grant_id", 32'(grant_id), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_timeout_err", 32'(timeout_err), 32'd0);

    // single request, normal path
    post(0, 8'h41);
    step();
    check("single_ack", 32'(req_ack), 32'b001);
    check("single_tx_ctrl_on", 32'(tx_ctrl), 32'd1);
    check("single_busy", 32'(busy), 32'd1);
    hi = 0;
    while (tx_ctrl === 1'b1 && hi < 10) begin
      hi++;
      step();
    end
    check("single_tx_ctrl_cycles", 32'(hi), 32'd2);
    bad = 0;
    cyc = 0;
    while (busy === 1'b1 && cyc < 100) begin
      if (tx_byte !== 8'h41) bad++;
      cyc++;
      step();
    end
    check("single_tx_byte_hold", 32'(bad), 32'd0);
    check("single_done", 32'(busy), 32'd0);
    check("single_frame_seen", 32'(exp_q.size()), 32'd0);

    // contention: two requesters, four frames
    reset_dut();
    post(0, 8'h11); post(1, 8'h22); post(0, 8'h11); post(1, 8'h22);
    ng = 0; nr = 0; cyc = 0; viol = 0;
    prev_tx = 1'b0; prev_busy = 1'b0;
    while ((ng < 4 || nr < 4) && cyc < 600) begin
      step();
      cyc++;
      if (req_ack != '0 && ng < 4) begin gids[ng] = grant_id; ng++; end
      if (m_done && nr < 4) begin rxs[nr] = m_rx; nr++; end
      if (tx_ctrl && !prev_tx && prev_busy) viol++;
      prev_tx = tx_ctrl;
      prev_busy = busy;
    end
    check("cont_grants", 32'(ng), 32'd4);
    check("cont_frames", 32'(nr), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check("cont_grant_order", 32'(gids[i]), 32'(i % 2));
      check("cont_serial", 32'(rxs[i]), (i % 2 == 0) ? 32'h11 : 32'h22);
    end
    check("cont_idle_gap", 32'(viol), 32'd0);

    // transmitter busy at request
    model_en = 1'b0;
    force_ready = 1'b0;
    reset_dut();
    post(1, 8'h5A);
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (req_ack != '0) bad++;
    end
    check("busy_no_ack", 32'(bad), 32'd0);
    check("busy_idle", 32'(busy), 32'd0);
    force_ready = 1'b1;
    step();
    check("busy_ack", 32'(req_ack), 32'b010);
    check("busy_grant_id", 32'(grant_id), 32'd1);
    check("busy_tx_byte", 32'(tx_byte), 32'h5A);
    force_ready = 1'b0;
    step();
    check("launch_exit_tx_ctrl", 32'(tx_ctrl), 32'd0);
    check("frame_busy", 32'(busy), 32'd1);

    // reset mid-frame
    rst = 1'b1;
    step();
    check("midrst_tx_ctrl", 32'(tx_ctrl), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_grant_id", 32'(grant_id), 32'd0);
    check("midrst_tx_byte", 32'(tx_byte), 32'd0);
    rst = 1'b0;
    post(0, 8'h33);
    post(2, 8'h66);
    force_ready = 1'b1;
    step();
    check("midrst_next_ack", 32'(req_ack), 32'b001);
    force_ready = 1'b0; step();
    force_ready = 1'b1; step();
    step();
    check("midrst_second_ack", 32'(req_ack), 32'b100);
    force_ready = 1'b0; step();
    force_ready = 1'b1; step();
    step();

    // launch watchdog
    reset_dut();
    force_ready = 1'b1;
    post(0, 8'h77);
    step();
    hi = 0;
    while (tx_ctrl === 1'b1 && hi < 40) begin
      hi++;
      step();
    end
`ifdef UART_TX_SCHED_TIMEOUT_EN
    check("to_tx_ctrl_cycles", 32'(hi), 32'd16);
    check("to_err_set", 32'(timeout_err), 32'd1);
    check("to_back_idle", 32'(busy), 32'd0);
    post(1, 8'h88);
    step();
    check("to_next_ack", 32'(req_ack), 32'b010);
    force_ready = 1'b0; step();
    force_ready = 1'b1; step();
    check("to_err_sticky", 32'(timeout_err), 32'd1);
    reset_dut();
    check("to_err_cleared", 32'(timeout_err), 32'd0);
`else
    check("nto_tx_ctrl_cycles", 32'(hi), 32'd40);
    check("nto_tx_ctrl_held", 32'(tx_ctrl), 32'd1);
    check("nto_err_zero", 32'(timeout_err), 32'd0);
    reset_dut();
    check("nto_rst_tx_ctrl", 32'(tx_ctrl), 32'd0);
`endif

    // randomized traffic
    model_en = 1'b1;
    reset_dut();
    acks0 = n_acks;
    for (int n = 0; n < 30; n++) begin
      post(int'($urandom_range(0, NREQ - 1)), 8'($urandom_range(0, 255)));
      repeat ($urandom_range(0, 50)) step();
    end
    cyc = 0;
    while ((src_q.size() > 0 || pend != '0 || busy || exp_q.size() > 0) && cyc < 6000) begin
      step();
      cyc++;
    end
    check("rand_drained", 32'(cyc < 6000), 32'd1);
    check("rand_ack_count", 32'(n_acks - acks0), 32'd30);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/uart_tx_scheduler.md
# uart_tx_scheduler

Shares the single `uart_tx` transmitter between `NUM_REQ` byte producers, for example the game-logic word sender and the keypad echo path. It arbitrates round-robin among pending requests and latches the winning byte. It then launches the frame through the `tx_ctrl`/`transmit_ready` handshake and holds `tx_byte` stable until the frame completes. The block sits directly between the producers and `uart_tx`, and drives its `tx_ctrl` and `tx_byte` inputs.

## Interface
- `NUM_REQ`, default 2: number of requesters (2..8).
- `TIMEOUT`, default 16: maximum cycles LAUNCH waits for `transmit_ready` to fall.
- `clk` in 1: system clock; the only clock.
- `rst` in 1: reset; synchronous, active-high.
- `req_valid` in NUM_REQ: bit i high means requester i has a byte pending; the byte is held until acked.
- `req_byte` in 8*NUM_REQ: flattened bytes; requester i uses bits [8i+7:8i].
- `req_ack` out NUM_REQ: one-cycle pulse to the winner in the cycle its byte is latched.
- `transmit_ready` in 1: from `uart_tx`; high only while the transmitter is idle.
- `tx_ctrl` out 1: launch request to `uart_tx`.
- `tx_byte` out 8: latched byte; stable from launch through frame end.
- `grant_id` out $clog2(NUM_REQ): index of the current or last granted requester.
- `busy` out 1: high in every state except IDLE.
- `timeout_err` out 1: sticky watchdog flag.

## Operation
- All outputs and state are registered.
- Reset values: state IDLE, `tx_ctrl`=0, `tx_byte`=0, `req_ack`=0, `grant_id`=0, `busy`=0, `timeout_err`=0, last-grant pointer = NUM_REQ-1, so requester 0 wins first.
- **IDLE**
  - If any `req_valid` bit is high and `transmit_ready`=1, select the winner by round-robin, searching from pointer+1 upward with wrap-around.
  - At the next edge: latch `req_byte` of the winner into `tx_byte`, pulse `req_ack`, update `grant_id` and the pointer, set `tx_ctrl`=1, and go to LAUNCH.
  - If `transmit_ready`=0, no grant is made and the block stays in IDLE.
- **LAUNCH**
  - Hold `tx_ctrl`=1 until `transmit_ready` is sampled 0.
  - Then clear `tx_ctrl` and go to FRAME.
- **FRAME**
  - Hold `tx_byte`.
  - Go to IDLE when `transmit_ready` is sampled 1.
- Only the winner sees `req_ack`; losers keep `req_valid` high and are served in later rounds.
- With a single requester active, it is granted on every round.
- `req_valid` dropping after the grant has no effect; the latched byte is still sent.

## Timing
- Request to launch: `req_valid`=1 at edge k in IDLE gives `req_ack` and `tx_ctrl` high after edge k+1.
- Against `uart_tx`, `transmit_ready` falls one cycle after `tx_ctrl` is seen. `tx_ctrl` is therefore high for 2 cycles in the normal case.
- Back-to-back frames: at least one IDLE cycle separates the return of `transmit_ready` from the next `tx_ctrl`.
- Reset mid-frame:
  - At the next edge every register returns to its reset value and `tx_ctrl` drops.
  - The acked byte is lost. The transmitter is not reset by this block.

## Configuration
- `UART_TX_SCHED_TIMEOUT_EN` defined:
  - LAUNCH counts its cycles.
  - If `transmit_ready` is still 1 after TIMEOUT cycles, the block clears `tx_ctrl`, sets `timeout_err`=1, and returns to IDLE, discarding the byte.
  - `timeout_err` stays set until `rst`.
  - The counter width is $clog2(TIMEOUT+1).
- Not defined: LAUNCH waits indefinitely, no counter is built, and `timeout_err` is tied 0.

## Structure
- Package `uart_tx_sched_pkg` contains:
  - the state enum {IDLE, LAUNCH, FRAME};
  - the byte-width constant (8);
  - a `MAX_REQ` constant (8).
- One sub-module, `tx_rr_arbiter`, which is combinational. Inputs: `req_valid` and the pointer. Outputs: a one-hot grant and the index. It is instantiated once.

## Test plan
- Single request, normal path: reset, then `req_valid`=01 and byte 0x41 with a `uart_tx` model (Clkperbaud=4). Required: `req_ack`=01 one cycle after the request; `tx_byte`=0x41 held until `transmit_ready` returns; `tx_ctrl` high for 2 cycles.
- Contention: both requesters valid with bytes 0x11 and 0x22, held for 4 frames. Required: grant order 0,1,0,1 and the serial output sequence 0x11,0x22,0x11,0x22.
- Transmitter busy at request: `transmit_ready`=0 when `req_valid` rises. Required: no ack until `transmit_ready`=1, then ack on the next edge.
- Reset mid-frame: assert `rst` in FRAME. Required: after the next edge `tx_ctrl`=0, `busy`=0, `grant_id`=0; a subsequent grant goes to requester 0.
- Timeout (macro on, TIMEOUT=16): tie `transmit_ready`=1 and request. Required: `tx_ctrl` high for 16 cycles, then low; `timeout_err`=1 until `rst`; the block returns to IDLE and the next request is granted. With the macro off, the same stimulus leaves `tx_ctrl` high indefinitely and `timeout_err`=0.
